aes_mix_columns_iter: RTL and testbench
=======================================

# aes_mix_columns_iter

Iterative AES-128 MixColumns stage that consumes a 128-bit state and applies the GF(2^8) column transform using ×2 and ×3 byte multipliers. It sits in the encryption round datapath directly downstream of ShiftRows and upstream of AddRoundKey. It processes a configurable number of columns per clock behind valid/ready handshakes on both sides.

## Interface
- COLS_PER_CYCLE, default 1: columns transformed per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream state word is valid.
- in_ready  output  1  block can accept a state word.
- in_data  input  128  input state in FIPS-197 byte order: byte s[r][c] = in_data[127-8*(4c+r) -: 8].
- out_valid  output  1  transformed state is available.
- out_ready  input  1  downstream accepts the state.
- out_data  output  128  MixColumns(in_data), same byte order as in_data.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load in_data into state_q, clear col_cnt, go to RUN.
  - RUN: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of state_q with their transformed values, then col_cnt += COLS_PER_CYCLE. After the cycle that processes column 3, go to DONE.
  - DONE: out_valid=1 and out_data=state_q. On out_ready, go to IDLE.
- Column transform, for input column a0..a3 (row 0 first):
  - b0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - b1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - b2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - b3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- Byte multiplication:
  - 2·x = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00)
  - 3·x = 2·x ^ x
  - All arithmetic is 8-bit XOR with no carries.
- col_cnt is 2 bits wide and wraps to 0 after the final column. Its value is only meaningful in RUN.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and upstream must hold its data.
- out_data is stable while out_valid=1 and out_ready=0. Upstream activity cannot change it.
- out_data is driven from state_q in all states. Its value is don't-care outside DONE, but it must never be X after reset.

## Timing
- Reset values (asynchronous, on rst_n low):
  - FSM = IDLE, so in_ready=1.
  - out_valid=0.
  - state_q = 128'h0, so out_data=0.
  - col_cnt=0.
- Latency: with the input handshake at edge N, out_valid rises after edge N + 4/COLS_PER_CYCLE. That is 4, 2 or 1 RUN cycles.
- Output handshake: completes at the edge where out_valid&&out_ready. The next cycle is IDLE, so the earliest next accept is one edge later.
- Minimum initiation interval = 4/COLS_PER_CYCLE + 2 cycles.
- Back-pressure: DONE is held indefinitely while out_ready=0.
- Reset asserted mid-RUN or mid-DONE:
  - The current block is discarded and no out_valid pulse is produced.
  - After rst_n deasserts, the first handshake is accepted on the first clock edge.
- out_ready asserted while not in DONE has no effect.

## Structure
- Package aes_pkg holds:
  - AES_NB = 4 and STATE_W = 128.
  - Byte/word/state typedefs.
  - Function xtime(byte) for ×2.
  - Function gmul3(byte) = xtime(b)^b, which keeps this block consistent with the existing ×3 table.
- Sub-module mix_single_column: combinational, 32-bit column in to 32-bit column out. It is instantiated COLS_PER_CYCLE times. Its input-column selection is a mux on col_cnt.
- Top level contains only the FSM, col_cnt, state_q and the handshake logic.

## Test plan
- FIPS-197 columns with COLS_PER_CYCLE=1: input db135345_f20a225c_01010101_c6c6c6c6 must produce 8e4da1bc_9fdc589d_01010101_c6c6c6c6. out_valid must rise exactly 4 edges after the accept.
- Same stimulus with COLS_PER_CYCLE=2 and with COLS_PER_CYCLE=4: same result, with latency 2 and 1 respectively.
- Input d4d4d4d5_2d26314c_00000000_ffffffff must produce d5d5d7d6_4d7ebdf8_00000000_ffffffff. This covers the 8'h1b reduction path and all-zero/all-one columns.
- Back-pressure: hold out_ready=0 for 10 cycles while toggling in_valid and in_data.
  - in_ready must stay 0.
  - out_data must stay constant.
  - Raising out_ready must complete the transfer, after which IDLE accepts the next word.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles.
  - Immediately: out_valid=0, in_ready=1, out_data=0.
  - A subsequent block must produce the correct result with no leftover state.
- Randomized stream of 1000 blocks with random in_valid/out_ready, compared against a reference model. Check: no dropped or duplicated blocks, and interval ≥ 4/COLS_PER_CYCLE+2 cycles.

Source files
------------

// File: rtl/aes_mix_columns_iter_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns datapath.
package aes_pkg;
  localparam int AES_NB  = 4;
  localparam int STATE_W = 128;

  typedef logic [7:0]         byte_t;
  typedef logic [31:0]        word_t;
  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mc_state_e;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Kept as xtime^b so results match the existing x3 table bit for bit.
  function automatic byte_t gmul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction
endpackage

// File: rtl/aes_mix_columns_iter_mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column (row 0 in the MSB byte).
module mix_single_column
  import aes_pkg::*;
(
  input  word_t col_i,
  output word_t col_o
);
  byte_t a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  assign col_o[31:24] = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
  assign col_o[7:0]   = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns: loads a state, transforms COLS_PER_CYCLE columns per
// cycle in place, then holds the result until the downstream handshake.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(AES_NB - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e  st_q, st_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     state_q, state_d;

  word_t cols_w   [AES_NB];
  word_t lane_in  [COLS_PER_CYCLE];
  word_t lane_out [COLS_PER_CYCLE];

  for (genvar c = 0; c < AES_NB; c++) begin : g_cols
    assign cols_w[c] = state_q[STATE_W-1-32*c -: 32];
  end

  // Lane i always works on column col_cnt+i; the 2-bit add wraps naturally.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_lane
    assign lane_in[i] = cols_w[col_cnt_q + 2'(i)];
    mix_single_column u_mix (
      .col_i (lane_in[i]),
      .col_o (lane_out[i])
    );
  end

  always_comb begin
    st_d      = st_q;
    col_cnt_d = col_cnt_q;
    state_d   = state_q;
    unique case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = in_data;
          col_cnt_d = 2'd0;
          st_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int c = 0; c < AES_NB; c++) begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            if (col_cnt_q + 2'(i) == 2'(c)) state_d[STATE_W-1-32*c -: 32] = lane_out[i];
          end
        end
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST) st_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= ST_IDLE;
      col_cnt_q <= 2'd0;
      state_q   <= '0;
    end else begin
      st_q      <= st_d;
      col_cnt_q <= col_cnt_d;
      state_q   <= state_d;
    end
  end

  assign in_ready  = (st_q == ST_IDLE);
  assign out_valid = (st_q == ST_DONE);
  assign out_data  = state_q;
endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed and random-stream bench for aes_mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_aes_mix_columns_iter;
  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam int NBLK = 1000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [127:0] din = '0;
  logic iv1 = 0, or1 = 0, iv2 = 0, or2 = 0, iv4 = 0, or4 = 0;
  logic ir1, ov1, ir2, ov2, ir4, ov4;
  logic [127:0] od1, od2, od4;
  int errs = 0, checks = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(din),
    .out_valid(ov1), .out_ready(or1), .out_data(od1));
  aes_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(din),
    .out_valid(ov2), .out_ready(or2), .out_data(od2));
  aes_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(din),
    .out_valid(ov4), .out_ready(or4), .out_data(od4));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  function automatic logic [127:0] mixcols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      r[127-8*(4*c+0) -: 8] = m2(a[0]) ^ m2(a[1]) ^ a[1] ^ a[2] ^ a[3];
      r[127-8*(4*c+1) -: 8] = a[0] ^ m2(a[1]) ^ m2(a[2]) ^ a[2] ^ a[3];
      r[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ m2(a[2]) ^ m2(a[3]) ^ a[3];
      r[127-8*(4*c+3) -: 8] = m2(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ m2(a[3]);
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ov(input int w);
    case (w) 1: return ov1; 2: return ov2; default: return ov4; endcase
  endfunction
  function automatic logic get_ir(input int w);
    case (w) 1: return ir1; 2: return ir2; default: return ir4; endcase
  endfunction
  function automatic logic [127:0] get_od(input int w);
    case (w) 1: return od1; 2: return od2; default: return od4; endcase
  endfunction
  task automatic set_iv(input int w, input logic v);
    case (w) 1: iv1 = v; 2: iv2 = v; default: iv4 = v; endcase
  endtask
  task automatic set_or(input int w, input logic v);
    case (w) 1: or1 = v; 2: or2 = v; default: or4 = v; endcase
  endtask

  // Accept one block, measure edges to out_valid, check result, drain it.
  task automatic run_block(input int w, input logic [127:0] d, input logic [127:0] exp,
                           input int lat, input string tag);
    int n;
    chk({tag, ".in_ready"}, get_ir(w), 1);
    din = d;
    set_iv(w, 1'b1);
    tick;
    set_iv(w, 1'b0);
    n = 0;
    while (!get_ov(w) && n < 20) begin
      tick;
      n++;
    end
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".data"}, get_od(w), exp);
    set_or(w, 1'b1);
    tick;
    set_or(w, 1'b0);
    chk({tag, ".drained"}, {get_ov(w), get_ir(w)}, 2'b01);
  endtask

  initial begin
    logic [127:0] q [$];
    int got, nacc, last, lim, n;

    // Reset state
    tick; tick;
    chk("rst.in_ready", ir1, 1);
    chk("rst.out_valid", ov1, 0);
    chk("rst.out_data", od1, '0);
    chk("rst.c4_out_data", od4, '0);
    rst_n = 1'b1;
    tick;

    run_block(1, V1, E1, 4, "fips_c1");
    run_block(1, V2, E2, 4, "red_c1");

    // Back-pressure: DONE holds while upstream churns
    din = V2; iv1 = 1'b1;
    tick;
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin tick; n++; end
    for (int k = 0; k < 10; k++) begin
      iv1 = 1'($urandom_range(0, 1));
      din = {$urandom, $urandom, $urandom, $urandom};
      tick;
      chk("bp.in_ready", ir1, 0);
      chk("bp.out_valid", ov1, 1);
      chk("bp.out_data", od1, E2);
    end
    iv1 = 1'b0; or1 = 1'b1;
    tick;
    or1 = 1'b0;
    chk("bp.release", {ov1, ir1}, 2'b01);
    run_block(1, V1, E1, 4, "after_bp");

    // Reset two cycles into RUN
    din = V2; iv1 = 1'b1;
    tick;
    iv1 = 1'b0;
    tick; tick;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", ov1, 0);
    chk("midrst.in_ready", ir1, 1);
    chk("midrst.out_data", od1, '0);
    tick;
    rst_n = 1'b1;
    run_block(1, V1, E1, 4, "after_rst");

    run_block(2, V1, E1, 2, "fips_c2");
    run_block(4, V1, E1, 1, "fips_c4");
    run_block(4, V2, E2, 1, "red_c4");

    // Random stream on the single-column instance
    got = 0; nacc = 0; last = 0;
    lim = cyc + 40000;
    fork
      begin : drv
        for (int k = 0; k < NBLK && cyc < lim; k++) begin
          logic [127:0] d;
          logic acc, rdy, v;
          d = {$urandom, $urandom, $urandom, $urandom};
          din = d;
          acc = 1'b0;
          while (!acc && cyc < lim) begin
            if (!iv1) iv1 = ($urandom_range(0, 2) == 0);
            rdy = ir1; v = iv1;
            tick;
            if (v && rdy) acc = 1'b1;
          end
          if (acc) begin
            q.push_back(mixcols(d));
            if (nacc > 0) chk("stream.interval_ge6", (cyc - last) >= 6, 1);
            last = cyc;
            nacc++;
          end
          iv1 = 1'b0;
        end
      end
      begin : mon
        while (got < NBLK && cyc < lim) begin
          logic v;
          logic [127:0] d;
          or1 = 1'($urandom_range(0, 1));
          v = ov1; d = od1;
          tick;
          if (v && or1) begin
            if (q.size() == 0) chk("stream.extra_block", 1, 0);
            else chk("stream.data", d, q.pop_front());
            got++;
          end
        end
        or1 = 1'b0;
      end
    join
    chk("stream.count", got, NBLK);
    chk("stream.leftover", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
